neural_scan_sequencer: RTL and testbench

- Channel-scan controller for the multiplexed neural ADC that feeds the acquisition front end.
- Walks a masked list of electrode channels and steers the analog mux for each one.
- For each channel it waits out mux settling, issues a conversion start, and waits for the ADC result.
- Emits one tagged sample per channel plus frame-boundary markers, which drive the front end's adc_data_in / adc_channel_in / adc_valid_in.

---
 rtl/neural_scan_sequencer.sv | 170 +++++++++++++++++
 tb/tb_neural_scan_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neural_scan_sequencer.sv
// Masked channel-scan sequencer for the multiplexed neural ADC.
// Define NEURAL_SCAN_FRAME_CNT_EN to add the frame_cnt output.
module neural_scan_sequencer #(
  parameter int NUM_CH         = 16,
  parameter int CH_ID_WIDTH    = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   sensor_clk,
  input  logic                   sensor_rst,
  input  logic                   scan_en,
  input  logic [NUM_CH-1:0]      ch_mask,
  input  logic                   err_clr,
  output logic [CH_ID_WIDTH-1:0] mux_sel,
  output logic                   adc_start,
  input  logic                   adc_done,
  input  logic [DATA_WIDTH-1:0]  adc_data,
  output logic [DATA_WIDTH-1:0]  samp_data,
  output logic [CH_ID_WIDTH-1:0] samp_channel,
  output logic                   samp_valid,
  output logic                   frame_start,
  output logic                   frame_end,
  output logic                   busy,
  output logic                   timeout_err
`ifdef NEURAL_SCAN_FRAME_CNT_EN
  ,
  output logic [15:0]            frame_cnt
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, SELECT, SETTLE, START, WAIT, NEXT
  } state_t;

  state_t            state, state_next;
  logic [NUM_CH-1:0] shadow_mask, shadow_next, served;
  logic [7:0]        settle_cnt;
  logic [TW-1:0]     to_cnt;
  logic [CH_ID_WIDTH-1:0] last_ch;
  logic              first_pend;
  logic              latch, emit, tmo, frame_done;

  function automatic logic [CH_ID_WIDTH-1:0] lowest(
    input logic [NUM_CH-1:0] m
  );
    lowest = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i]) lowest = CH_ID_WIDTH'(i);
  endfunction

  function automatic logic [CH_ID_WIDTH-1:0] highest(
    input logic [NUM_CH-1:0] m
  );
    highest = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (m[i]) highest = CH_ID_WIDTH'(i);
  endfunction

  assign served    = NUM_CH'(1) << mux_sel;
  assign adc_start = (state == START);
  assign busy      = (state != IDLE);

  always_comb begin
    state_next  = state;
    shadow_next = shadow_mask;
    latch       = 1'b0;
    emit        = 1'b0;
    tmo         = 1'b0;
    frame_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (scan_en && (ch_mask != '0)) begin
          latch       = 1'b1;
          shadow_next = ch_mask;
          state_next  = SELECT;
        end
      end
      SELECT: state_next = SETTLE;
      SETTLE: begin
        if (settle_cnt <= 8'd1) state_next = START;
      end
      START: state_next = WAIT;
      WAIT: begin
        if (adc_done) begin
          emit       = 1'b1;
          state_next = NEXT;
        end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          tmo        = 1'b1;
          state_next = NEXT;
        end
      end
      NEXT: begin
        shadow_next = shadow_mask & ~served;
        if (shadow_next == '0) begin
          frame_done = 1'b1;
          if (scan_en && (ch_mask != '0)) begin
            latch       = 1'b1;
            shadow_next = ch_mask;
            state_next  = SELECT;
          end else begin
            state_next = IDLE;
          end
        end else begin
          state_next = SELECT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // mux_sel moves on entry to SELECT so the SELECT cycle also settles
  always_ff @(posedge sensor_clk) begin
    if (sensor_rst) begin
      state        <= IDLE;
      shadow_mask  <= '0;
      settle_cnt   <= '0;
      to_cnt       <= '0;
      last_ch      <= '0;
      first_pend   <= 1'b0;
      mux_sel      <= '0;
      samp_data    <= '0;
      samp_channel <= '0;
      samp_valid   <= 1'b0;
      frame_start  <= 1'b0;
      frame_end    <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state       <= state_next;
      shadow_mask <= shadow_next;
      samp_valid  <= emit;
      frame_start <= emit & first_pend;
      frame_end   <= emit & (mux_sel == last_ch);
      if (emit) begin
        samp_data    <= adc_data;
        samp_channel <= mux_sel;
        first_pend   <= 1'b0;
      end
      if (latch) begin
        first_pend <= 1'b1;
        last_ch    <= highest(ch_mask);
      end
      if (state_next == SELECT) mux_sel <= lowest(shadow_next);
      if (state == SELECT)
        settle_cnt <= 8'(SETTLE_CYCLES);
      else if (state == SETTLE && settle_cnt != 8'd0)
        settle_cnt <= settle_cnt - 8'd1;
      if (state == START)
        to_cnt <= '0;
      else if (state == WAIT)
        to_cnt <= to_cnt + 1'b1;
      if (tmo)
        timeout_err <= 1'b1;
      else if (err_clr)
        timeout_err <= 1'b0;
    end
  end

`ifdef NEURAL_SCAN_FRAME_CNT_EN
  always_ff @(posedge sensor_clk) begin
    if (sensor_rst)
      frame_cnt <= '0;
    else if (frame_done)
      frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_neural_scan_sequencer.sv
// Directed bench for neural_scan_sequencer with an ADC model
// and a sample scoreboard.
module tb_neural_scan_sequencer;

  localparam int NUM_CH = 16;
  localparam int CW     = 4;
  localparam int DW     = 16;
  localparam int SETTLE = 4;
  localparam int TMO    = 64;
  localparam int LAT    = 3;

  typedef struct packed {
    logic [CW-1:0] ch;
    logic [DW-1:0] data;
    logic          fs;
    logic          fe;
  } samp_t;

  logic clk = 1'b0;
  logic rst, scan_en, err_clr, adc_done;
  logic [NUM_CH-1:0] ch_mask;
  logic [DW-1:0] adc_data, samp_data;
  logic [CW-1:0] mux_sel, samp_channel;
  logic adc_start, samp_valid, frame_start, frame_end;
  logic busy, timeout_err;
`ifdef NEURAL_SCAN_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_start = 0;
  int n_samp = 0;
  samp_t exp_q[$];
  logic [DW-1:0] data_tab [NUM_CH];
  logic mute_tab [NUM_CH];
  int cd = 0;
  logic [DW-1:0] data_cap = '0;
  logic mute_cap = 1'b0;
  logic [CW-1:0] mux_prev = '0;
  logic busy_prev = 1'b0;
  int sel_cyc = 0;
  bit sel_valid = 1'b0;
  int samp_cyc = 0;
  int samp_gap = 0;

  always #5 clk = ~clk;

  neural_scan_sequencer dut (
    .sensor_clk  (clk),
    .sensor_rst  (rst),
    .scan_en     (scan_en),
    .ch_mask     (ch_mask),
    .err_clr     (err_clr),
    .mux_sel     (mux_sel),
    .adc_start   (adc_start),
    .adc_done    (adc_done),
    .adc_data    (adc_data),
    .samp_data   (samp_data),
    .samp_channel(samp_channel),
    .samp_valid  (samp_valid),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .busy        (busy),
    .timeout_err (timeout_err)
`ifdef NEURAL_SCAN_FRAME_CNT_EN
    ,
    .frame_cnt   (frame_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int ch, input bit fs, input bit fe);
    samp_t e;
    e.ch   = CW'(ch);
    e.data = data_tab[ch];
    e.fs   = fs;
    e.fe   = fe;
    exp_q.push_back(e);
  endtask

  // One clock: ADC model response, start latency, sample scoreboard.
  task automatic tick();
    samp_t got, want;
    @(posedge clk);
    #1;
    cyc++;
    adc_done = 1'b0;
    adc_data = '0;
    if (cd > 0) begin
      cd--;
      if (cd == 0 && !mute_cap) begin
        adc_done = 1'b1;
        adc_data = data_cap;
      end
    end
    if (mux_sel !== mux_prev || (busy && !busy_prev)) begin
      sel_cyc   = cyc;
      sel_valid = 1'b1;
    end
    mux_prev  = mux_sel;
    busy_prev = busy;
    if (adc_start) begin
      n_start++;
      if (sel_valid)
        chk("start_latency", 32'(cyc - sel_cyc), 32'(SETTLE + 1));
      sel_valid = 1'b0;
      cd        = LAT;
      data_cap  = data_tab[mux_sel];
      mute_cap  = mute_tab[mux_sel];
    end
    if (samp_valid) begin
      n_samp++;
      samp_gap = cyc - samp_cyc;
      samp_cyc = cyc;
      got.ch   = samp_channel;
      got.data = samp_data;
      got.fs   = frame_start;
      got.fe   = frame_end;
      if (exp_q.size() == 0) begin
        chk("unexpected_sample", 32'(got), 32'hFFFF_FFFF);
      end else begin
        want = exp_q.pop_front();
        chk("sample", 32'(got), 32'(want));
      end
    end
  endtask

  task automatic pulse_scan(input logic [NUM_CH-1:0] m);
    ch_mask = m;
    scan_en = 1'b1;
    tick();
    scan_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    tick();
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_start(output int t);
    int n = 0;
    tick();
    while (!adc_start && n < 500) begin
      tick();
      n++;
    end
    chk("start_seen", 32'(adc_start), 32'd1);
    t = cyc;
  endtask

  task automatic run_to(input int target, input int gap_from);
    int n = 0;
    while (n_samp < target && n < 2000) begin
      tick();
      n++;
      if (samp_valid && n_samp >= gap_from)
        chk("sample_spacing", 32'(samp_gap), 32'd10);
    end
    if (n_samp < target) chk("sample_wait", 32'(n_samp), 32'(target));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mux"}, 32'(mux_sel), 32'd0);
    chk({tag, "_start"}, 32'(adc_start), 32'd0);
    chk({tag, "_valid"}, 32'(samp_valid), 32'd0);
    chk({tag, "_data"}, 32'(samp_data), 32'd0);
    chk({tag, "_chan"}, 32'(samp_channel), 32'd0);
    chk({tag, "_fs"}, 32'(frame_start), 32'd0);
    chk({tag, "_fe"}, 32'(frame_end), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    int base, st0, t0, t1, s0;
    rst = 1'b1;
    scan_en = 1'b0;
    ch_mask = '0;
    err_clr = 1'b0;
    adc_done = 1'b0;
    adc_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      data_tab[i] = 16'hC000 | 16'(i * 257);
      mute_tab[i] = 1'b0;
    end
    data_tab[0] = 16'h1234;
    data_tab[2] = 16'h5678;

    // reset state
    tick();
    tick();
    rst = 1'b0;
    chk_zero("reset");
`ifdef NEURAL_SCAN_FRAME_CNT_EN
    chk("reset_frame_cnt", 32'(frame_cnt), 32'd0);
`endif

    // single frame, mask 0x0005
    st0 = n_start;
    push(0, 1'b1, 1'b0);
    push(2, 1'b0, 1'b1);
    pulse_scan(16'h0005);
    wait_idle("single_idle");
    chk("single_starts", 32'(n_start - st0), 32'd2);
    chk("single_drained", 32'(exp_q.size()), 32'd0);

    // continuous scan, 3 frames of 0x8001
    for (int f = 0; f < 3; f++) begin
      push(0, 1'b1, 1'b0);
      push(15, 1'b0, 1'b1);
    end
    base = n_samp;
    ch_mask = 16'h8001;
    scan_en = 1'b1;
    run_to(base + 5, base + 2);
    scan_en = 1'b0;
    wait_idle("cont_idle");
    chk("cont_count", 32'(n_samp - base), 32'd6);
    chk("cont_last_spacing", 32'(samp_gap), 32'd10);

    // mask change mid-frame
    push(0, 1'b1, 1'b0);
    push(1, 1'b0, 1'b0);
    push(2, 1'b0, 1'b0);
    push(3, 1'b0, 1'b1);
    push(4, 1'b1, 1'b1);
    base = n_samp;
    ch_mask = 16'h000F;
    scan_en = 1'b1;
    run_to(base + 2, 1 << 30);
    ch_mask = 16'h0010;
    run_to(base + 4, 1 << 30);
    tick();
    scan_en = 1'b0;
    wait_idle("mask_idle");
    chk("mask_count", 32'(n_samp - base), 32'd5);

    // timeout on ch 1 of mask 0x0003
    mute_tab[1] = 1'b1;
    push(0, 1'b1, 1'b0);
    base = n_samp;
    pulse_scan(16'h0003);
    wait_start(t0);
    wait_start(t1);
    chk("tmo_chan", 32'(mux_sel), 32'd1);
    while (cyc < t1 + TMO) tick();
    chk("tmo_not_early", 32'(timeout_err), 32'd0);
    tick();
    chk("tmo_set", 32'(timeout_err), 32'd1);
    wait_idle("tmo_idle");
    for (int i = 0; i < 5; i++) tick();
    chk("tmo_sticky", 32'(timeout_err), 32'd1);
    chk("tmo_samples", 32'(n_samp - base), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr", 32'(timeout_err), 32'd0);

    // timeout and err_clr in the same cycle
    pulse_scan(16'h0002);
    wait_start(t1);
    while (cyc < t1 + TMO) tick();
    chk("same_pre", 32'(timeout_err), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("same_set_wins", 32'(timeout_err), 32'd1);
    wait_idle("same_idle");
    mute_tab[1] = 1'b0;

    // reset during WAIT; ADC still answers afterwards
    base = n_samp;
    pulse_scan(16'h0001);
    wait_start(t0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero("midrst");
    s0 = n_start;
    for (int i = 0; i < 12; i++) tick();
    chk("midrst_no_sample", 32'(n_samp - base), 32'd0);
    chk("midrst_no_start", 32'(n_start - s0), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);

    // empty mask with scan_en high
    s0 = n_start;
    ch_mask = '0;
    scan_en = 1'b1;
    t0 = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy) t0++;
    end
    scan_en = 1'b0;
    chk("empty_no_start", 32'(n_start - s0), 32'd0);
    chk("empty_busy_cycles", 32'(t0), 32'd0);

    // two more completed frames
    push(1, 1'b1, 1'b1);
    pulse_scan(16'h0002);
    wait_idle("cnt_idle0");
    push(5, 1'b1, 1'b0);
    push(6, 1'b0, 1'b1);
    pulse_scan(16'h0060);
    wait_idle("cnt_idle1");
`ifdef NEURAL_SCAN_FRAME_CNT_EN
    chk("frame_cnt", 32'(frame_cnt), 32'd2);
`endif

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
